// File: rtl/alu_core_pkg.sv
// Shared definitions for the datapath ALU: default width, opcode map and result-class decode.
package alu_core_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [7:0] OP_ADD_RR = 8'h03;
    localparam logic [7:0] OP_ADD_RI = 8'h04;
    localparam logic [7:0] OP_ADD_II = 8'h05;
    localparam logic [7:0] OP_SUB_RR = 8'h06;
    localparam logic [7:0] OP_SUB_RI = 8'h07;
    localparam logic [7:0] OP_SUB_II = 8'h08;
    localparam logic [7:0] OP_CMP_RR = 8'h09;
    localparam logic [7:0] OP_CMP_RI = 8'h0A;
    localparam logic [7:0] OP_CMP_II = 8'h0B;

    typedef enum logic [1:0] {
        ALU_ZERO = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2
    } alu_fn_e;

    // Addressing mode (reg/imm) only matters to the sequencer; the ALU just adds or subtracts.
    function automatic alu_fn_e decode_fn(input logic [7:0] opc);
        alu_fn_e fn;
        fn = ALU_ZERO;
        case (opc)
            OP_ADD_RR, OP_ADD_RI, OP_ADD_II: fn = ALU_ADD;
            OP_SUB_RR, OP_SUB_RI, OP_SUB_II: fn = ALU_SUB;
            default:                         fn = ALU_ZERO;
        endcase
        return fn;
    endfunction

endpackage

// File: rtl/alu_operand_reg.sv
// Operand latch: WIDTH-bit register with synchronous reset and load enable.
// Latency: q updates one clock after load; holds otherwise.
// Backpressure: none, load is unconditional when asserted.
module alu_operand_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_core.sv
// Bus ALU: latches A/B from the data bus, drives add/sub result onto shared bus_out, latches compare flags.
// Latency: out is combinational from registered A/B; operands and flags update one clock after their enable.
// Backpressure: none; the sequencer guarantees a single enabled bus_out driver per cycle.
import alu_core_pkg::*;

module alu_core #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_enable_in,
    input  logic             b_enable_in,
    input  logic             c_enable_out,
    input  logic             flags_enable_in,
    input  logic [WIDTH-1:0] operation,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             equal,
    output logic             greater,
    output logic             lesser
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result;
    logic [7:0]       opc8;
    alu_fn_e          alu_fn;

    alu_operand_reg #(.WIDTH(WIDTH)) u_reg_a (
        .clk   (clk),
        .reset (reset),
        .load  (a_enable_in),
        .d     (in),
        .q     (a_q)
    );

    alu_operand_reg #(.WIDTH(WIDTH)) u_reg_b (
        .clk   (clk),
        .reset (reset),
        .load  (b_enable_in),
        .d     (in),
        .q     (b_q)
    );

    // Opcode map is defined on 8 bits; resize so the decode works for any WIDTH.
    assign opc8   = 8'(operation);
    assign alu_fn = decode_fn(opc8);

    always_comb begin
        result = '0;
        case (alu_fn)
            ALU_ADD: result = a_q + b_q;
            ALU_SUB: result = a_q - b_q;
            default: result = '0;
        endcase
    end

    assign out = c_enable_out ? result : {WIDTH{1'bz}};

    // Compare uses the pre-edge operands, so a same-cycle load is not yet reflected.
    always_ff @(posedge clk) begin
        if (reset) begin
            equal   <= 1'b0;
            greater <= 1'b0;
            lesser  <= 1'b0;
        end else if (flags_enable_in) begin
            equal   <= (a_q == b_q);
            greater <= (a_q >  b_q);
            lesser  <= (a_q <  b_q);
        end
    end

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

    logic       clk;
    logic       reset;
    logic       a_enable_in;
    logic       b_enable_in;
    logic       c_enable_out;
    logic       flags_enable_in;
    logic [7:0] operation;
    logic [7:0] bus_in;
    wire  [7:0] bus_out;
    logic       equal;
    logic       greater;
    logic       lesser;

    // Second driver on the shared bus, standing in for another datapath unit.
    logic       tb_drv_en;
    logic [7:0] tb_drv_val;
    assign bus_out = tb_drv_en ? tb_drv_val : 8'hzz;

    int checks;
    int failures;

    alu_core #(.WIDTH(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .a_enable_in     (a_enable_in),
        .b_enable_in     (b_enable_in),
        .c_enable_out    (c_enable_out),
        .flags_enable_in (flags_enable_in),
        .operation       (operation),
        .in              (bus_in),
        .out             (bus_out),
        .equal           (equal),
        .greater         (greater),
        .lesser          (lesser)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] v);
        a_enable_in = 1'b1;
        bus_in      = v;
        tick();
        a_enable_in = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] v);
        b_enable_in = 1'b1;
        bus_in      = v;
        tick();
        b_enable_in = 1'b0;
    endtask

    task automatic latch_flags();
        flags_enable_in = 1'b1;
        tick();
        flags_enable_in = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        c_enable_out = 1'b1;
        operation    = 8'h03;
        tick();
        reset = 1'b0;
        checks++;
        if (bus_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_out got=%h exp=00", bus_out);
        end
        checks++;
        if ({equal, greater, lesser} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000", {equal, greater, lesser});
        end
    endtask

    task automatic test_add();
        operation = 8'h03;
        load_a(8'h05);
        load_b(8'h07);
        c_enable_out = 1'b1;
        checks++;
        if (bus_out !== 8'h0C) begin
            failures++;
            $display("FAIL add_rr got=%h exp=0c", bus_out);
        end
        operation = 8'h04;
        load_a(8'hFF);
        load_b(8'h02);
        checks++;
        if (bus_out !== 8'h01) begin
            failures++;
            $display("FAIL add_ri_wrap got=%h exp=01", bus_out);
        end
        operation = 8'h05;
        load_a(8'h80);
        load_b(8'h80);
        checks++;
        if (bus_out !== 8'h00) begin
            failures++;
            $display("FAIL add_ii_carry got=%h exp=00", bus_out);
        end
        // Compare and unknown opcodes must not produce a result.
        operation = 8'h09;
        checks++;
        if (bus_out !== 8'h00) begin
            failures++;
            $display("FAIL cmp_op_zero got=%h exp=00", bus_out);
        end
        operation = 8'h02;
        checks++;
        if (bus_out !== 8'h00) begin
            failures++;
            $display("FAIL op02_zero got=%h exp=00", bus_out);
        end
    endtask

    task automatic test_sub();
        operation = 8'h06;
        load_a(8'h03);
        load_b(8'h05);
        c_enable_out = 1'b1;
        checks++;
        if (bus_out !== 8'hFE) begin
            failures++;
            $display("FAIL sub_rr got=%h exp=fe", bus_out);
        end
        operation = 8'h08;
        load_a(8'h00);
        load_b(8'h01);
        checks++;
        if (bus_out !== 8'hFF) begin
            failures++;
            $display("FAIL sub_ii_wrap got=%h exp=ff", bus_out);
        end
        operation = 8'h07;
        load_a(8'h50);
        load_b(8'h20);
        checks++;
        if (bus_out !== 8'h30) begin
            failures++;
            $display("FAIL sub_ri got=%h exp=30", bus_out);
        end
        // Release the bus: the other driver's value must come through untouched.
        c_enable_out = 1'b0;
        tb_drv_val   = 8'h5A;
        tb_drv_en    = 1'b1;
        #1;
        checks++;
        if (bus_out !== 8'h5A) begin
            failures++;
            $display("FAIL bus_release_5a got=%h exp=5a", bus_out);
        end
        tb_drv_val = 8'h01;
        #1;
        checks++;
        if (bus_out !== 8'h01) begin
            failures++;
            $display("FAIL bus_release_01 got=%h exp=01", bus_out);
        end
        tb_drv_en    = 1'b0;
        c_enable_out = 1'b1;
        #1;
        checks++;
        if (bus_out !== 8'h30) begin
            failures++;
            $display("FAIL bus_reenable got=%h exp=30", bus_out);
        end
    endtask

    task automatic test_flags();
        load_a(8'h10);
        load_b(8'h10);
        latch_flags();
        checks++;
        if ({equal, greater, lesser} !== 3'b100) begin
            failures++;
            $display("FAIL flags_equal got=%b exp=100", {equal, greater, lesser});
        end
        load_a(8'h20);
        latch_flags();
        checks++;
        if ({equal, greater, lesser} !== 3'b010) begin
            failures++;
            $display("FAIL flags_greater got=%b exp=010", {equal, greater, lesser});
        end
        load_a(8'h01);
        latch_flags();
        checks++;
        if ({equal, greater, lesser} !== 3'b001) begin
            failures++;
            $display("FAIL flags_lesser got=%b exp=001", {equal, greater, lesser});
        end
        // Same-edge load of A=0x30: flags still see old A=0x01 < B=0x10.
        a_enable_in     = 1'b1;
        bus_in          = 8'h30;
        flags_enable_in = 1'b1;
        tick();
        a_enable_in     = 1'b0;
        flags_enable_in = 1'b0;
        checks++;
        if ({equal, greater, lesser} !== 3'b001) begin
            failures++;
            $display("FAIL flags_pre_edge got=%b exp=001", {equal, greater, lesser});
        end
        // Without the enable the flags hold even though A>B now.
        tick();
        checks++;
        if ({equal, greater, lesser} !== 3'b001) begin
            failures++;
            $display("FAIL flags_hold got=%b exp=001", {equal, greater, lesser});
        end
        latch_flags();
        checks++;
        if ({equal, greater, lesser} !== 3'b010) begin
            failures++;
            $display("FAIL flags_relatch got=%b exp=010", {equal, greater, lesser});
        end
    endtask

    task automatic test_back_to_back();
        a_enable_in = 1'b1;
        b_enable_in = 1'b1;
        bus_in      = 8'h2A;
        tick();
        a_enable_in  = 1'b0;
        b_enable_in  = 1'b0;
        operation    = 8'h06;
        c_enable_out = 1'b1;
        #1;
        checks++;
        if (bus_out !== 8'h00) begin
            failures++;
            $display("FAIL same_load_sub got=%h exp=00", bus_out);
        end
        operation = 8'h03;
        #1;
        checks++;
        if (bus_out !== 8'h54) begin
            failures++;
            $display("FAIL same_load_add got=%h exp=54", bus_out);
        end
        latch_flags();
        checks++;
        if ({equal, greater, lesser} !== 3'b100) begin
            failures++;
            $display("FAIL same_load_flags got=%b exp=100", {equal, greater, lesser});
        end
    endtask

    task automatic test_mid_reset();
        load_a(8'h09);
        load_b(8'h04);
        latch_flags();
        operation = 8'h03;
        checks++;
        if (bus_out !== 8'h0D) begin
            failures++;
            $display("FAIL pre_reset_add got=%h exp=0d", bus_out);
        end
        reset       = 1'b1;
        a_enable_in = 1'b1;
        bus_in      = 8'h77;
        tick();
        reset       = 1'b0;
        a_enable_in = 1'b0;
        checks++;
        if (bus_out !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_add got=%h exp=00", bus_out);
        end
        checks++;
        if ({equal, greater, lesser} !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset_flags got=%b exp=000", {equal, greater, lesser});
        end
        operation = 8'h06;
        #1;
        checks++;
        if (bus_out !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_sub got=%h exp=00", bus_out);
        end
        latch_flags();
        checks++;
        if ({equal, greater, lesser} !== 3'b100) begin
            failures++;
            $display("FAIL post_reset_flags got=%b exp=100", {equal, greater, lesser});
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b0;
        a_enable_in     = 1'b0;
        b_enable_in     = 1'b0;
        c_enable_out    = 1'b0;
        flags_enable_in = 1'b0;
        operation       = 8'h00;
        bus_in          = 8'h00;
        tb_drv_en       = 1'b0;
        tb_drv_val      = 8'h00;

        test_reset();
        test_add();
        test_sub();
        test_flags();
        test_back_to_back();
        test_mid_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
